term_ctrl: RTL and testbench

TERM_CTRL -- requirements
Module: term_ctrl

---
 rtl/term_ctrl_pkg.sv | 15 +
 rtl/term_addr.sv | 17 +
 rtl/term_ctrl.sv | 177 +++++++++++++++++
 tb/tb_term_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/term_ctrl_pkg.sv
// term_ctrl_pkg: state encoding, character codes and helpers shared by the terminal controller.
package term_ctrl_pkg;
  localparam int ADDR_W = 12;
  typedef enum logic [1:0] {IDLE, ESC, CSI, CLEAR} state_e;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_SPACE = 8'h20;
  // CSI parameters are 1-based with 0 meaning 1; this yields the 0-based index.
  function automatic logic [7:0] dec1(input logic [7:0] p);
    return p == 8'd0 ? 8'd0 : p - 8'd1;
  endfunction
endpackage

// File: rtl/term_addr.sv
// term_addr: maps a logical row/column through the scroll offset to a character-RAM address.
module term_addr import term_ctrl_pkg::*; #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic [4:0]        row_i,
  input  logic [6:0]        col_i,
  input  logic [4:0]        scroll_i,
  output logic [ADDR_W-1:0] addr_o
);
  logic [5:0] sum;
  logic [4:0] phys;
  // Both operands are below ROWS, so one conditional subtract replaces the modulo.
  assign sum    = {1'b0, row_i} + {1'b0, scroll_i};
  assign phys   = sum >= 6'(ROWS) ? 5'(sum - 6'(ROWS)) : sum[4:0];
  assign addr_o = ADDR_W'(phys) * ADDR_W'(COLS) + ADDR_W'(col_i);
endmodule

// File: rtl/term_ctrl.sv
// term_ctrl: byte-stream text terminal writing a character RAM, with scrolling and a small CSI subset.
module term_ctrl import term_ctrl_pkg::*; #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_complete,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic [4:0]  scroll_row,
  output logic        busy,
  output logic        overflow
);
  localparam logic [6:0]  XMAX      = 7'(COLS - 1);
  localparam logic [4:0]  YMAX      = 5'(ROWS - 1);
  localparam logic [11:0] LAST_CELL = 12'(ROWS * COLS - 1);
  state_e      state_q, state_d;
  logic [6:0]  x_q, x_d;
  logic [4:0]  y_q, y_d, scr_q, scr_d;
  logic [7:0]  pend_q, pend_d, p0_q, p0_d, p1_q, p1_d;
  logic        pv_q, pv_d, idx_q, idx_d, full_q, full_d;
  logic [11:0] cnt_q, cnt_d, waddr_q, waddr_d, cell_addr;
  logic [7:0]  wdata_q, wdata_d;
  logic        wen_q, wen_d, busy_q, busy_d, ovf_q, ovf_d;
  logic        go, lf;
  logic [7:0]  byte_c, cur, pnew, tab, hx, hy;
  logic [11:0] acc;
  term_addr #(.COLS(COLS), .ROWS(ROWS)) u_addr (
    .row_i    (y_q),
    .col_i    (state_q == CLEAR ? cnt_q[6:0] : x_q),
    .scroll_i (scr_q),
    .addr_o   (cell_addr)
  );
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    scr_d   = scr_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    byte_c  = pv_q ? pend_q : rx_data;
    wen_d   = 1'b0;
    waddr_d = cell_addr;
    wdata_d = byte_c;
    busy_d  = 1'b0;
    ovf_d   = 1'b0;
    go      = 1'b0;
    lf      = 1'b0;
    cur     = idx_q ? p1_q : p0_q;
    acc     = {4'd0, cur} * 12'd10 + {8'd0, byte_c[3:0]};
    pnew    = acc > 12'd255 ? 8'hFF : acc[7:0];
    tab     = {1'b0, x_q[6:3] + 4'd1, 3'd0};
    hy      = dec1(p0_q);
    hx      = dec1(p1_q);
    if (state_q == CLEAR) begin
      wen_d   = 1'b1;
      wdata_d = CH_SPACE;
      busy_d  = 1'b1;
      waddr_d = full_q ? cnt_q : cell_addr;
      cnt_d   = cnt_q + 12'd1;
      state_d = cnt_q == (full_q ? LAST_CELL : {5'd0, XMAX}) ? IDLE : CLEAR;
      ovf_d   = rx_complete & pv_q;
      pv_d    = pv_q | rx_complete;
      pend_d  = pv_q | ~rx_complete ? pend_q : rx_data;
    end else begin
      // A held byte takes priority; a coinciding strobe refills the slot.
      go     = pv_q | rx_complete;
      pv_d   = pv_q & rx_complete;
      pend_d = rx_data;
    end
    if (go)
      case (state_q)
        IDLE: begin
          if (byte_c >= CH_SPACE && byte_c <= 8'h7E) begin
            wen_d = 1'b1;
            lf    = x_q == XMAX;
            x_d   = lf ? 7'd0 : x_q + 7'd1;
          end else if (byte_c == CH_CR) x_d = 7'd0;
          else if (byte_c == CH_LF) lf = 1'b1;
          else if (byte_c == CH_BS) x_d = x_q == 7'd0 ? 7'd0 : x_q - 7'd1;
          else if (byte_c == CH_TAB) x_d = tab > {1'b0, XMAX} ? XMAX : tab[6:0];
          else if (byte_c == CH_ESC) state_d = ESC;
        end
        ESC: begin
          state_d = byte_c == "[" ? CSI : IDLE;
          p0_d    = 8'd0;
          p1_d    = 8'd0;
          idx_d   = 1'b0;
        end
        CSI: begin
          if (byte_c >= "0" && byte_c <= "9") begin
            p0_d = idx_q ? p0_q : pnew;
            p1_d = idx_q ? pnew : p1_q;
          end else if (byte_c == ";") idx_d = 1'b1;
          else if (byte_c >= 8'h40 && byte_c <= 8'h7E) begin
            state_d = IDLE;
            if (byte_c == "H") begin
              y_d = hy > {3'd0, YMAX} ? YMAX : hy[4:0];
              x_d = hx > {1'b0, XMAX} ? XMAX : hx[6:0];
            end else if (byte_c == "J" && p0_q == 8'd2) begin
              state_d = CLEAR;
              full_d  = 1'b1;
              cnt_d   = '0;
            end else if (byte_c == "K") begin
              state_d = CLEAR;
              full_d  = 1'b0;
              cnt_d   = {5'd0, x_q};
            end
          end
        end
        default: ;
      endcase
    // At the bottom row the screen scrolls and the newly exposed row is blanked.
    if (lf) begin
      if (y_q == YMAX) begin
        scr_d   = scr_q == YMAX ? 5'd0 : scr_q + 5'd1;
        state_d = CLEAR;
        full_d  = 1'b0;
        cnt_d   = '0;
      end else y_d = y_q + 5'd1;
    end
  end
  always_ff @(posedge clk100 or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      scr_q   <= '0;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      p0_q    <= '0;
      p1_q    <= '0;
      idx_q   <= 1'b0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      scr_q   <= scr_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  assign wr_en      = wen_q;
  assign wr_addr    = waddr_q;
  assign wr_data    = wdata_q;
  assign cursor_x   = x_q;
  assign cursor_y   = y_q;
  assign scroll_row = scr_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_term_ctrl.sv
// tb_term_ctrl: directed stimulus with a write scoreboard for term_ctrl.
module tb_term_ctrl;
  logic        clk100 = 1'b0, rst_n = 1'b1, rx_complete = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        wr_en, busy, overflow;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y, scroll_row;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;
  int checks = 0, errors = 0, busy_cnt = 0, ovf_cnt = 0;
  term_ctrl dut (
    .clk100      (clk100),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_complete (rx_complete),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .scroll_row  (scroll_row),
    .busy        (busy),
    .overflow    (overflow)
  );
  always #5 clk100 = ~clk100;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask
  task automatic exp_w(input int addr, input logic [7:0] data);
    exp_q.push_back({12'(addr), data});
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk100);
    rx_data     = b;
    rx_complete = 1'b1;
    @(negedge clk100);
    rx_complete = 1'b0;
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_cursor_x"}, cursor_x, 0);
    chk({tag, "_cursor_y"}, cursor_y, 0);
    chk({tag, "_scroll_row"}, scroll_row, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask
  task automatic do_reset();
    @(negedge clk100);
    rst_n = 1'b0;
    #1 chk("reset_wr_en", wr_en, 0);
    @(negedge clk100);
    rst_n = 1'b1;
  endtask
  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk100);
      n++;
    end
    @(negedge clk100);
    chk(tag, exp_q.size(), 0);
  endtask
  task automatic wait_busy(input string tag, input int target, input int budget);
    int n = 0;
    while (busy_cnt < target && n < budget) begin
      @(negedge clk100);
      n++;
    end
    chk(tag, busy_cnt >= target, 1);
  endtask
  always @(negedge clk100)
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (overflow) ovf_cnt++;
      if (wr_en) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write: got addr %0d data %h, expected no write", wr_addr, wr_data);
        end
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          checks++;
          assert ({wr_addr, wr_data} === mon_e) else begin
            errors++;
            $error("FAIL write: got addr %0d data %h, expected addr %0d data %h",
                   wr_addr, wr_data, mon_e[19:8], mon_e[7:0]);
          end
        end
      end
    end
  initial begin
    #1 rst_n = 1'b0;
    #10 check_zero("reset");
    @(negedge clk100);
    rst_n = 1'b1;
    exp_w(0, "A");
    exp_w(1, "B");
    send("A");
    chk("wr_latency", wr_en, 1);
    @(negedge clk100);
    chk("wr_single_cycle", wr_en, 0);
    send("B");
    send(8'h0D);
    send(8'h0A);
    chk("crlf_x", cursor_x, 0);
    chk("crlf_y", cursor_y, 1);
    do_reset();
    for (int i = 0; i < 81; i++) exp_w(i, "x");
    for (int i = 0; i < 81; i++) send("x");
    chk("wrap_x", cursor_x, 1);
    chk("wrap_y", cursor_y, 1);
    send(8'h1B);
    send_str("[30H");
    chk("bottom_y", cursor_y, 29);
    chk("bottom_x", cursor_x, 0);
    for (int i = 0; i < 80; i++) exp_w(i, 8'h20);
    busy_cnt = 0;
    send(8'h0A);
    drain("scroll_clear_done", 300);
    chk("scroll_busy_cycles", busy_cnt, 80);
    chk("scroll_row", scroll_row, 1);
    chk("scroll_hold_y", cursor_y, 29);
    exp_w(0, "Q");
    exp_w(1, "R");
    send("Q");
    send("R");
    do_reset();
    send(8'h1B);
    send_str("[5;10H");
    chk("csi_h_y", cursor_y, 4);
    chk("csi_h_x", cursor_x, 9);
    exp_w(329, "Z");
    send("Z");
    chk("after_z_x", cursor_x, 10);
    send(8'h09);
    chk("tab_x", cursor_x, 16);
    send(8'h08);
    chk("bs_x", cursor_x, 15);
    send(8'h1B);
    send_str("[99;200H");
    chk("clamp_y", cursor_y, 29);
    chk("clamp_x", cursor_x, 79);
    send(8'h1B);
    send_str("[0;0H");
    chk("zero_param_y", cursor_y, 0);
    chk("zero_param_x", cursor_x, 0);
    send(8'h08);
    chk("bs_saturate", cursor_x, 0);
    send(8'h1B);
    send_str("[257H");
    chk("param_saturate_y", cursor_y, 29);
    send(8'h1B);
    send_str("[1;77H");
    chk("pos_x76", cursor_x, 76);
    send(8'h09);
    chk("tab_clamp", cursor_x, 79);
    send(8'h1B);
    send_str("[3;75H");
    for (int i = 234; i < 240; i++) exp_w(i, 8'h20);
    send(8'h1B);
    send_str("[K");
    drain("erase_line_done", 50);
    chk("erase_line_x", cursor_x, 74);
    chk("erase_line_y", cursor_y, 2);
    send(8'h7F);
    send(8'h01);
    send(8'h1B);
    send("A");
    chk("ignored_x", cursor_x, 74);
    exp_w(234, "B");
    send("B");
    chk("esc_abort_x", cursor_x, 75);
    do_reset();
    for (int i = 0; i < 2400; i++) exp_w(i, 8'h20);
    busy_cnt = 0;
    ovf_cnt  = 0;
    send(8'h1B);
    send_str("[2J");
    wait_busy("clear_reach_100", 100, 300);
    exp_w(0, "M");
    send("M");
    wait_busy("clear_reach_200", 200, 300);
    send("N");
    drain("full_clear_done", 3000);
    chk("full_clear_busy_cycles", busy_cnt, 2400);
    chk("overflow_pulses", ovf_cnt, 1);
    chk("pending_x", cursor_x, 1);
    chk("pending_y", cursor_y, 0);
    for (int i = 0; i < 2400; i++) exp_w(i, 8'h20);
    busy_cnt = 0;
    send(8'h1B);
    send_str("[2J");
    wait_busy("clear_reach_10", 10, 100);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_clear");
    exp_q.delete();
    repeat (3) @(negedge clk100);
    rst_n = 1'b1;
    repeat (20) @(negedge clk100);
    chk("post_abort_busy", busy, 0);
    chk("post_abort_wr_en", wr_en, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
